// File: rtl/paddle_control_arbiter_if.sv
// ---------------------------------------------------------------------------
// paddle_control_arbiter_if
// Groups the frame-sync, player, position and paddle-command signals of the
// paddle control arbiter.
//   slave  : arbiter side (vsync, buttons, positions in; move/status out)
//   master : driver side  (the opposite directions)
// force_cpu exists only when PADDLE_ARB_FORCE_CPU_EN is defined.
// ---------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 10
`endif

interface paddle_control_arbiter_if;
  logic                       vertical_sync;
  logic                       btn_forward;
  logic                       btn_backward;
  logic [`POSITION_WIDTH-1:0] paddle_y;
  logic [`POSITION_WIDTH-1:0] ball_y;
`ifdef PADDLE_ARB_FORCE_CPU_EN
  logic                       force_cpu;
`endif
  logic                       move_forward;
  logic                       move_backward;
  logic                       cpu_active;
  logic                       handover;

  modport slave (
`ifdef PADDLE_ARB_FORCE_CPU_EN
    input  force_cpu,
`endif
    input  vertical_sync, btn_forward, btn_backward, paddle_y, ball_y,
    output move_forward, move_backward, cpu_active, handover
  );

  modport master (
`ifdef PADDLE_ARB_FORCE_CPU_EN
    output force_cpu,
`endif
    output vertical_sync, btn_forward, btn_backward, paddle_y, ball_y,
    input  move_forward, move_backward, cpu_active, handover
  );
endinterface

// File: rtl/paddle_control_arbiter.sv
// ---------------------------------------------------------------------------
// paddle_control_arbiter
// Decides once per frame (vsync rising edge) whether the paddle follows the
// human buttons or the built-in ball tracker, and issues move_forward /
// move_backward for the whole following frame.
//
// Ports:
//   pixel_clock : system clock
//   reset_n     : asynchronous active-low reset
//   bus         : paddle_control_arbiter_if.slave (vsync, raw buttons,
//                 paddle_y, ball_y in; move_*, cpu_active, handover out)
//
// Optional feature: PADDLE_ARB_FORCE_CPU_EN adds bus.force_cpu, which pins
// the paddle to CPU control while high and hands back via HANDOVER on release.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_HUMAN  | buttons drive the paddle; counting button-free frames
// ST_CPU    | tracker drives the paddle toward the ball
// ST_HANDOVER | forced no-move hold-off before returning to the human
// ---------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 10
`endif

module paddle_control_arbiter #(
  parameter logic [`POSITION_WIDTH-1:0] PADDLE_LENGTH   = `POSITION_WIDTH'd200,
  parameter logic [`POSITION_WIDTH-1:0] DEADBAND        = `POSITION_WIDTH'd8,
  parameter logic [15:0]                IDLE_FRAMES     = 16'd600,
  parameter logic [7:0]                 HANDOVER_FRAMES = 8'd30
) (
  input  logic                     pixel_clock,
  input  logic                     reset_n,
  paddle_control_arbiter_if.slave  bus
);

  localparam int W = `POSITION_WIDTH;

  typedef enum logic [1:0] {
    ST_HUMAN    = 2'd0,
    ST_CPU      = 2'd1,
    ST_HANDOVER = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_btn_f_meta, r_btn_f_s, r_btn_b_meta, r_btn_b_s;
  logic        r_last_vsync;
  logic [15:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [7:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic [1:0]  r_move, w_move_raw, w_move_nxt, w_track;
  logic        r_cpu_active, r_handover;
  logic        w_tick, w_any_btn;
  logic [7:0]  w_hold_last;
  logic [W+1:0] w_centre, w_ball, w_db;

`ifdef PADDLE_ARB_FORCE_CPU_EN
  logic r_force_meta, r_force_s, r_forced, w_forced_nxt;
`endif

  // Synchronisers and vsync edge history run every cycle.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_f_meta <= 1'b0;
      r_btn_f_s    <= 1'b0;
      r_btn_b_meta <= 1'b0;
      r_btn_b_s    <= 1'b0;
      r_last_vsync <= 1'b0;
    end else begin
      r_btn_f_meta <= bus.btn_forward;
      r_btn_f_s    <= r_btn_f_meta;
      r_btn_b_meta <= bus.btn_backward;
      r_btn_b_s    <= r_btn_b_meta;
      r_last_vsync <= bus.vertical_sync;
    end
  end

`ifdef PADDLE_ARB_FORCE_CPU_EN
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_force_meta <= 1'b0;
      r_force_s    <= 1'b0;
    end else begin
      r_force_meta <= bus.force_cpu;
      r_force_s    <= r_force_meta;
    end
  end
`endif

  assign w_tick    = bus.vertical_sync & ~r_last_vsync;
  assign w_any_btn = r_btn_f_s | r_btn_b_s;

  // A zero-length hold-off behaves as a single frame.
  assign w_hold_last = (HANDOVER_FRAMES == 8'd0) ? 8'd0 : HANDOVER_FRAMES - 8'd1;

  // Two guard bits: the centre can exceed the screen and adding the deadband
  // must not wrap, so the tracker never reverses direction near the edges.
  assign w_centre = {2'b00, bus.paddle_y} + {3'b000, PADDLE_LENGTH[W-1:1]};
  assign w_ball   = {2'b00, bus.ball_y};
  assign w_db     = {2'b00, DEADBAND};
  assign w_track  = (w_ball > w_centre + w_db) ? 2'b10 :
                    (w_ball + w_db < w_centre) ? 2'b01 : 2'b00;

  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_move_raw     = 2'b00;
`ifdef PADDLE_ARB_FORCE_CPU_EN
    w_forced_nxt   = r_forced;
`endif
    case (r_state)
      ST_HUMAN: begin
        w_move_raw = {r_btn_f_s, r_btn_b_s};
        if (w_any_btn)
          w_idle_cnt_nxt = 16'd0;
        else if (r_idle_cnt != IDLE_FRAMES)
          w_idle_cnt_nxt = r_idle_cnt + 16'd1;
        if (!w_any_btn && (r_idle_cnt == IDLE_FRAMES - 16'd1)) begin
          w_state_nxt = ST_CPU;
          w_move_raw  = 2'b00;
        end
      end
      ST_CPU: begin
        w_move_raw     = w_track;
        w_idle_cnt_nxt = 16'd0;
        if (w_any_btn) begin
          w_state_nxt    = ST_HANDOVER;
          w_move_raw     = 2'b00;
          w_hold_cnt_nxt = 8'd0;
        end
      end
      ST_HANDOVER: begin
        w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        if (r_hold_cnt == w_hold_last) begin
          w_state_nxt    = ST_HUMAN;
          w_idle_cnt_nxt = 16'd0;
          w_hold_cnt_nxt = 8'd0;
        end
      end
      default: w_state_nxt = ST_HUMAN;
    endcase
`ifdef PADDLE_ARB_FORCE_CPU_EN
    // Forcing overrides everything; releasing it always goes through the
    // hold-off so the player is not surprised by a moving paddle.
    if (r_force_s) begin
      w_forced_nxt   = 1'b1;
      w_state_nxt    = ST_CPU;
      w_idle_cnt_nxt = 16'd0;
      w_hold_cnt_nxt = 8'd0;
      w_move_raw     = (r_state == ST_CPU) ? w_track : 2'b00;
    end else if (r_forced) begin
      w_forced_nxt   = 1'b0;
      w_state_nxt    = ST_HANDOVER;
      w_hold_cnt_nxt = 8'd0;
      w_move_raw     = 2'b00;
    end
`endif
    w_move_nxt = (w_move_raw == 2'b11) ? 2'b00 : w_move_raw;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_HUMAN;
      r_idle_cnt   <= 16'd0;
      r_hold_cnt   <= 8'd0;
      r_move       <= 2'b00;
      r_cpu_active <= 1'b0;
      r_handover   <= 1'b0;
`ifdef PADDLE_ARB_FORCE_CPU_EN
      r_forced     <= 1'b0;
`endif
    end else if (w_tick) begin
      r_state      <= w_state_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_move       <= w_move_nxt;
      r_cpu_active <= (w_state_nxt == ST_CPU);
      r_handover   <= (w_state_nxt == ST_HANDOVER);
`ifdef PADDLE_ARB_FORCE_CPU_EN
      r_forced     <= w_forced_nxt;
`endif
    end
  end

  assign bus.move_forward  = r_move[1];
  assign bus.move_backward = r_move[0];
  assign bus.cpu_active    = r_cpu_active;
  assign bus.handover      = r_handover;

endmodule
